// File: rtl/interrupt_controller.sv
// 8259-style priority interrupt controller for the 8080 core: captures requests, masks them,
// and raises one interrupt by fixed priority, with the matching RST opcode, until end-of-interrupt.
module interrupt_controller #(
  parameter int NUM_SRC   = 8,
  parameter bit EDGE_TRIG = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_data,
  input  logic               inte,
  input  logic               inta,
  input  logic               eoi,
  output logic               interrupt,
  output logic [23:0]        interrupt_instruction,
  output logic [2:0]         active_vec,
  output logic               in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] irq_prev_q, mask_q, mask_d;
  logic [NUM_SRC-1:0] eligible, vec_oh, set_v, clr_v;
  logic               int_q, int_d, insvc_q, insvc_d, ack;
  logic [7:0]         op_q, op_d;
  logic [2:0]         vec_q, vec_d, winner;

  assign eligible = pending_q & ~mask_q;

  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (eligible[i]) winner = 3'(i);
  end

  always_comb begin
    vec_oh = '0;
    for (int i = 0; i < NUM_SRC; i++)
      vec_oh[i] = (vec_q == 3'(i));
  end

  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    insvc_d = insvc_q;
    op_d    = op_q;
    vec_d   = vec_q;
    ack     = 1'b0;
    unique case (state_q)
      IDLE: if (inte && (|eligible)) begin
        vec_d   = winner;
        int_d   = 1'b1;
        op_d    = 8'hC7 | {2'b00, winner, 3'b000};
        state_d = REQ;
      end
      REQ: begin
        // The latched winner stays frozen; only ack or withdrawal leaves REQ.
        if (inta) begin
          ack     = 1'b1;
          int_d   = 1'b0;
          op_d    = 8'h00;
          insvc_d = 1'b1;
          state_d = SERVICE;
        end else if (!inte || (|(mask_q & vec_oh))) begin
          int_d   = 1'b0;
          op_d    = 8'h00;
          state_d = IDLE;
        end
      end
      SERVICE: if (eoi) begin
        insvc_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh edge in the same cycle as the acknowledge survives the clear.
  always_comb begin
    set_v     = EDGE_TRIG ? (irq_in & ~irq_prev_q) : irq_in;
    clr_v     = ack ? vec_oh : '0;
    pending_d = EDGE_TRIG ? ((pending_q & ~clr_v) | set_v) : irq_in;
    mask_d    = mask_wr ? mask_data : mask_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      irq_prev_q <= '0;
      mask_q     <= '1;
      int_q      <= 1'b0;
      insvc_q    <= 1'b0;
      op_q       <= 8'h00;
      vec_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq_in;
      mask_q     <= mask_d;
      int_q      <= int_d;
      insvc_q    <= insvc_d;
      op_q       <= op_d;
      vec_q      <= vec_d;
    end
  end

  assign interrupt             = int_q;
  assign interrupt_instruction = {op_q, 16'h0000};
  assign active_vec            = vec_q;
  assign in_service            = insvc_q;

endmodule
